// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD bus arbiter: FSM state encoding and
// the HD44780 commands that need the long execution wait.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR,
        IDLE,
        H_SET,
        H_PUL,
        H_HLD,
        L_SET,
        L_PUL,
        L_HLD,
        EXEC
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Home ignores bit 0, so 0x03 is a home command as well.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || ({data[7:1], 1'b0} == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_arb_grant.sv
// Tie-break between the two LCD requesters. Fixed priority (requester 0 wins)
// by default; LCD_ARB_ROUND_ROBIN_EN adds a last-grant register for alternation.
module lcd_arb_grant (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) last_d = grant[1];
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
        else                grant = valid;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, accept};

    always_comb begin
        grant = 2'b00;
        if (valid[0])      grant = 2'b01;
        else if (valid[1]) grant = 2'b10;
    end
`endif

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 LCD (4-bit mode) between two requesters; each byte becomes two
// enable-strobed nibble writes. Round-robin tie-break when LCD_ARB_ROUND_ROBIN_EN is defined.
//
// state | meaning
// PWR   | LCD power-on hold-off after reset
// IDLE  | waiting for a request; accept happens here
// H_SET | high nibble on bus, en low
// H_PUL | high nibble, en high
// H_HLD | high nibble held, en low
// L_SET | low nibble on bus, en low
// L_PUL | low nibble, en high
// L_HLD | low nibble held, en low
// EXEC  | LCD execution wait; done pulses on the last cycle
module lcd_bus_arbiter #(
    parameter int unsigned PWR_WAIT = 2000000,
    parameter int unsigned EN_CYC   = 50,
    parameter int unsigned EXEC_CYC = 4000,
    parameter int unsigned LONG_CYC = 160000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic [1:0]  done,
    output logic        busy,
    output logic        rs,
    output logic        en,
    output logic        rw,
    output logic [3:0]  LCD_out
);
    import lcd_pkg::*;

    localparam logic [31:0] PWR_LD  = 32'(PWR_WAIT - 1);
    localparam logic [31:0] EN_LD   = 32'(EN_CYC - 1);
    localparam logic [31:0] EXEC_LD = 32'(EXEC_CYC - 1);
    localparam logic [31:0] LONG_LD = 32'(LONG_CYC - 1);

    lcd_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        gidx_q, gidx_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic [3:0]  lcd_q, lcd_d;
    logic [1:0]  done_q, done_d;

    logic [1:0]  grant;
    logic        accept;
    logic        sel_idx;
    logic [7:0]  sel_data;

    lcd_arb_grant u_grant (
        .clk    (Clk),
        .rst    (Rst),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel_idx   = grant[1];
    assign sel_data  = sel_idx ? req_data[15:8] : req_data[7:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gidx_d  = gidx_q;
        rs_d    = rs_q;
        lcd_d   = lcd_q;
        done_d  = 2'b00;
        if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;

        unique case (state_q)
            PWR:   if (cnt_q == 32'd0) state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    state_d = H_SET;
                    cnt_d   = EN_LD;
                    gidx_d  = sel_idx;
                    data_d  = sel_data;
                    rs_d    = req_rs[sel_idx];
                    lcd_d   = sel_data[7:4];
                end
            end
            H_SET: if (cnt_q == 32'd0) begin state_d = H_PUL; cnt_d = EN_LD; end
            H_PUL: if (cnt_q == 32'd0) begin state_d = H_HLD; cnt_d = EN_LD; end
            H_HLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = L_SET;
                    cnt_d   = EN_LD;
                    lcd_d   = data_q[3:0];
                end
            end
            L_SET: if (cnt_q == 32'd0) begin state_d = L_PUL; cnt_d = EN_LD; end
            L_PUL: if (cnt_q == 32'd0) begin state_d = L_HLD; cnt_d = EN_LD; end
            L_HLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = EXEC;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
                end
            end
            EXEC:  if (cnt_q == 32'd0) state_d = IDLE;
            default: begin
                state_d = PWR;
                cnt_d   = PWR_LD;
            end
        endcase

        en_d   = (state_d == H_PUL) || (state_d == L_PUL);
        busy_d = (state_d != IDLE);
        // Registered done lands on the final EXEC cycle.
        if ((state_d == EXEC) && (cnt_d == 32'd0)) done_d[gidx_d] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= PWR;
            cnt_q   <= PWR_LD;
            data_q  <= 8'h00;
            gidx_q  <= 1'b0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            lcd_q   <= 4'h0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gidx_q  <= gidx_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            lcd_q   <= lcd_d;
            done_q  <= done_d;
        end
    end

    assign rs      = rs_q;
    assign en      = en_q;
    assign rw      = 1'b0;
    assign busy    = busy_q;
    assign LCD_out = lcd_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: expected transfers are queued when a
// request is raised and checked against the accept, nibble and done activity.
module tb_lcd_bus_arbiter;

    localparam int PW = 10;
    localparam int EN = 2;
    localparam int EX = 5;
    localparam int LG = 20;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_rs = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_ready;
    logic [1:0]  done;
    logic        busy, rs, en, rw;
    logic [3:0]  LCD_out;

    lcd_bus_arbiter #(
        .PWR_WAIT (PW),
        .EN_CYC   (EN),
        .EXEC_CYC (EX),
        .LONG_CYC (LG)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .done      (done),
        .busy      (busy),
        .rs        (rs),
        .en        (en),
        .rw        (rw),
        .LCD_out   (LCD_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         who;
        int         lat;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   cur_v = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   ncyc = 0;
    int   acc_n = 0;
    int   en_cnt = 0;
    int   acc_cnt[2] = '{0, 0};
    int   rel_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int exp_lat(input logic r, input logic [7:0] b);
        bit long_c;
        long_c = !r && (b == 8'h01 || b == 8'h02 || b == 8'h03);
        return 6 * EN + (long_c ? LG : EX);
    endfunction

    task automatic push(input int who, input logic r, input logic [7:0] b);
        exp_t e;
        e.who = who;
        e.lat = exp_lat(r, b);
        e.hi  = b[7:4];
        e.lo  = b[3:0];
        e.rs  = r;
        sb.push_back(e);
    endtask

    task automatic drive(input int who, input logic r, input logic [7:0] b);
        if (who == 0) begin
            req_data[7:0] = b;
            req_rs[0]     = r;
        end else begin
            req_data[15:8] = b;
            req_rs[1]      = r;
        end
    endtask

    task automatic wait_acc(input int who, input int n0);
        int t = 0;
        while (acc_cnt[who] == n0 && t < 1000) begin
            @(posedge Clk); #1;
            t++;
        end
        check_eq("acc_seen", 32'(acc_cnt[who] - n0), 32'd1);
    endtask

    task automatic send(input int who, input logic r, input logic [7:0] b);
        int n0;
        n0 = acc_cnt[who];
        push(who, r, b);
        drive(who, r, b);
        req_valid[who] = 1'b1;
        wait_acc(who, n0);
        req_valid[who] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || cur_v) && t < 2000) begin
            @(posedge Clk); #1;
            t++;
        end
        check_eq("drain", 32'(sb.size()) + 32'(cur_v), 32'd0);
    endtask

    // Output monitor: one sample per cycle on the falling edge.
    initial forever begin
        @(negedge Clk);
        ncyc++;
        if (en) begin
            en_cnt++;
            check_eq("en_nib", 32'(LCD_out), 32'((en_cnt <= EN) ? cur.hi : cur.lo));
            check_eq("en_rs", 32'(rs), 32'(cur.rs));
            check_eq("rw", 32'(rw), 32'd0);
        end
        if (|done) begin
            if (cur_v) begin
                check_eq("done_who", 32'(done), 32'd1 << cur.who);
                check_eq("done_lat", 32'(ncyc - acc_n), 32'(cur.lat));
                check_eq("en_cycles", 32'(en_cnt), 32'(2 * EN));
                cur_v = 1'b0;
            end else begin
                check_eq("done_unexp", 32'(done), 32'd0);
            end
        end
        if (|req_ready) begin
            if (req_ready[0]) acc_cnt[0]++;
            if (req_ready[1]) acc_cnt[1]++;
            if (sb.size() > 0) begin
                cur    = sb.pop_front();
                cur_v  = 1'b1;
                acc_n  = ncyc;
                en_cnt = 0;
                check_eq("acc_who", 32'(req_ready), 32'd1 << cur.who);
            end else begin
                check_eq("acc_unexp", 32'(req_ready), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] tbl_b[6]  = '{8'h01, 8'h28, 8'h03, 8'h00, 8'h02, 8'h04};
    logic       tbl_rs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int tgt0, tgt1, base0, base1, t;
        bit first;

        // Power-on: requester 0 valid from reset onward.
        drive(0, 1'b1, 8'h41);
        push(0, 1'b1, 8'h41);
        req_valid = 2'b01;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_en", 32'(en), 32'd0);
        check_eq("rst_rs", 32'(rs), 32'd0);
        check_eq("rst_rw", 32'(rw), 32'd0);
        check_eq("rst_lcd", 32'(LCD_out), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        Rst = 1'b0;
        rel_n = ncyc + 1;
        wait_acc(0, 0);
        req_valid = 2'b00;
        check_eq("pwr_wait", 32'(acc_n - rel_n), 32'(PW));
        wait_idle();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single data byte from requester 1.
        send(1, 1'b1, 8'h57);
        wait_idle();

        // Command bytes around the long-wait boundary, alternating requesters.
        for (int i = 0; i < 6; i++) begin
            send(i % 2, tbl_rs[i], tbl_b[i]);
            wait_idle();
        end
        check_eq("idle_lcd", 32'(LCD_out), 32'h4);

        // Requester 0 raises and withdraws valid during another byte's EXEC.
        send(1, 1'b1, 8'h9C);
        repeat (13) @(posedge Clk);
        #1;
        drive(0, 1'b0, 8'h55);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("wd_ready", 32'(req_ready), 32'd0);
            check_eq("wd_en", 32'(en), 32'd0);
            check_eq("wd_lcd", 32'(LCD_out), 32'hC);
            check_eq("wd_rs", 32'(rs), 32'd1);
            @(posedge Clk); #1;
        end
        req_valid[0] = 1'b0;
        wait_idle();

        // Reset in the middle of L_PUL, then a tie from reset release.
        send(1, 1'b1, 8'hA5);
        t = 0;
        while (en_cnt != EN + 1 && t < 100) begin
            @(posedge Clk); #1;
            t++;
        end
        check_eq("reach_lpul", 32'(en_cnt), 32'(EN + 1));
        Rst   = 1'b1;
        cur_v = 1'b0;
        @(posedge Clk); #1;
        check_eq("mid_rst_en", 32'(en), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd1);
        check_eq("mid_rst_done", 32'(done), 32'd0);

        drive(0, 1'b1, 8'h30);
        drive(1, 1'b1, 8'h31);
`ifdef LCD_ARB_ROUND_ROBIN_EN
        tgt0 = 2; tgt1 = 2;
        push(0, 1'b1, 8'h30); push(1, 1'b1, 8'h31);
        push(0, 1'b1, 8'h30); push(1, 1'b1, 8'h31);
`else
        tgt0 = 3; tgt1 = 1;
        push(0, 1'b1, 8'h30); push(0, 1'b1, 8'h30);
        push(0, 1'b1, 8'h30); push(1, 1'b1, 8'h31);
`endif
        req_valid = 2'b11;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        base0 = acc_cnt[0];
        base1 = acc_cnt[1];
        Rst   = 1'b0;
        rel_n = ncyc + 1;
        first = 1'b1;
        t = 0;
        while (req_valid != 2'b00 && t < 500) begin
            @(posedge Clk); #1;
            t++;
            if (first && (acc_cnt[0] + acc_cnt[1] != base0 + base1)) begin
                first = 1'b0;
                check_eq("pwr_restart", 32'(acc_n - rel_n), 32'(PW));
            end
            if (acc_cnt[0] - base0 >= tgt0) req_valid[0] = 1'b0;
            if (acc_cnt[1] - base1 >= tgt1) req_valid[1] = 1'b0;
        end
        check_eq("tie_finished", 32'(req_valid), 32'd0);
        wait_idle();
        check_eq("tie_cnt0", 32'(acc_cnt[0] - base0), 32'(tgt0));
        check_eq("tie_cnt1", 32'(acc_cnt[1] - base1), 32'(tgt1));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
